// File: rtl/tpg_multi.sv
// tpg_multi: programmable raster timing generator with four test patterns
// (ramp, colour bars, checkerboard, solid). All outputs are registered, so
// they describe the raster position of the previous enabled cycle.
// Optional build macro TPG_FRAME_CNT_EN adds an 8-bit frame counter output
// and makes the ramp and checker patterns move from frame to frame.
module tpg_multi #(
    parameter int PW        = 8,
    parameter int H_BITS    = 12,
    parameter int V_BITS    = 12,
    parameter int BAR_SHIFT = 4,
    parameter int CHK_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [3*PW-1:0]   solid_rgb,
    input  logic [H_BITS-1:0] tHS_START,
    input  logic [H_BITS-1:0] tHS_END,
    input  logic [H_BITS-1:0] tHACT_START,
    input  logic [H_BITS-1:0] tHACT_END,
    input  logic [H_BITS-1:0] tH_END,
    input  logic [V_BITS-1:0] tVS_START,
    input  logic [V_BITS-1:0] tVS_END,
    input  logic [V_BITS-1:0] tVACT_START,
    input  logic [V_BITS-1:0] tVACT_END,
    input  logic [V_BITS-1:0] tV_END,
    output logic              hs_q,
    output logic              vs_q,
    output logic              vld_q,
    output logic              sof_q,
    output logic              eol_q,
`ifdef TPG_FRAME_CNT_EN
    output logic [7:0]        frame_cnt,
`endif
    output logic [3*PW-1:0]   rgb
);

    logic [H_BITS-1:0] x_q, x_d;
    logic [V_BITS-1:0] y_q, y_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [3*PW-1:0]   rgb_q, rgb_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              hs_d, vs_d, vld_d, sof_d, eol_d;

    logic              hs, vs, act, origin, line_end, frame_end;
    logic [H_BITS-1:0] hx, hx_chk;
    logic [V_BITS-1:0] vy;
    logic [2:0]        bar;
    logic [PW-1:0]     ramp;
    logic [PW-1:0]     ones;
    logic [3*PW-1:0]   pix;
    logic              unused_bits;

    assign ones = {PW{1'b1}};

    // Timing decode from the current raster position (half-open intervals)
    always_comb begin
        hs        = (x_q >= tHS_START) && (x_q < tHS_END);
        vs        = (y_q >= tVS_START) && (y_q < tVS_END);
        act       = (x_q >= tHACT_START) && (x_q < tHACT_END) &&
                    (y_q >= tVACT_START) && (y_q < tVACT_END);
        origin    = (x_q == '0) && (y_q == '0);
        line_end  = (x_q == tH_END);
        frame_end = line_end && (y_q == tV_END);
    end

    // Pattern generation relative to the top-left active pixel
    always_comb begin
        hx = x_q - tHACT_START;
        vy = y_q - tVACT_START;
`ifdef TPG_FRAME_CNT_EN
        hx_chk = hx + H_BITS'(frame_cnt_q);
        ramp   = cnt_q + PW'(frame_cnt_q);
`else
        hx_chk = hx;
        ramp   = cnt_q;
`endif
        bar = hx[BAR_SHIFT+2:BAR_SHIFT];
        pix = '0;
        case (mode_q)
            2'd0: pix = {ramp, ramp, ramp};
            2'd1: pix = {(bar[1] ? '0 : ones), (bar[2] ? '0 : ones), (bar[0] ? '0 : ones)};
            2'd2: pix = (hx_chk[CHK_SHIFT] ^ vy[CHK_SHIFT]) ? {3*PW{1'b1}} : '0;
            default: pix = solid_rgb;
        endcase
    end

    // Only a few bits of the relative coordinates feed the patterns
    assign unused_bits = &{1'b0, hx, hx_chk, vy};

    // Next-state: raster advance, pattern latch at frame start, output decode
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        vld_d       = 1'b0;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        rgb_d       = '0;
        if (en) begin
            hs_d  = hs;
            vs_d  = vs;
            vld_d = act;
            sof_d = act && (x_q == tHACT_START) && (y_q == tVACT_START);
            eol_d = act && (x_q == tHACT_END - H_BITS'(1));
            rgb_d = act ? pix : '0;
            if (line_end) begin
                x_d = '0;
                y_d = (y_q == tV_END) ? '0 : y_q + V_BITS'(1);
            end else begin
                x_d = x_q + H_BITS'(1);
            end
            if (origin) begin
                mode_d = mode;
                cnt_d  = '0;
            end else if (act) begin
                cnt_d = cnt_q + PW'(1);
            end
            if (frame_end)
                frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            frame_cnt_q <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            vld_q       <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            rgb_q       <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            vld_q       <= vld_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb = rgb_q;
`ifdef TPG_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`else
    logic unused_frame_cnt;
    assign unused_frame_cnt = &{1'b0, frame_cnt_q};
`endif

endmodule

// File: tb/tb_tpg_multi.sv
// Directed bench for tpg_multi: 16x10 raster, 8x6 active window.
module tb_tpg_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [11:0] tHS_START = 12'd0, tHS_END = 12'd2, tHACT_START = 12'd4, tHACT_END = 12'd12, tH_END = 12'd15;
    logic [11:0] tVS_START = 12'd0, tVS_END = 12'd1, tVACT_START = 12'd2, tVACT_END = 12'd8, tV_END = 12'd9;
    logic        hs_q, vs_q, vld_q, sof_q, eol_q;
    logic [23:0] rgb;
`ifdef TPG_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
`endif

    int tests = 0;
    int fails = 0;

    tpg_multi #(.PW(8), .H_BITS(12), .V_BITS(12), .BAR_SHIFT(1), .CHK_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .hs_q(hs_q), .vs_q(vs_q), .vld_q(vld_q), .sof_q(sof_q), .eol_q(eol_q),
`ifdef TPG_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Sample k: one active edge then the falling edge where outputs are read
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        int first;
        logic hs1, vs1;
        mode = 2'd0; en = 1'b1;
        rst = 1'b1;
        tick(); tick(); tick();
        tests++;
        if ({hs_q, vs_q, vld_q, sof_q, eol_q} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {hs_q, vs_q, vld_q, sof_q, eol_q});
        end
        tests++;
        if (rgb !== 24'h0) begin
            fails++; $display("FAIL reset_rgb got %h want 000000", rgb);
        end
        rst = 1'b0;
        first = 0; hs1 = 1'b0; vs1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin hs1 = hs_q; vs1 = vs_q; end
            if (vld_q && first == 0) first = k;
        end
        tests++;
        if ({hs1, vs1} !== 2'b11) begin
            fails++; $display("FAIL reset_first_sync got %b want 11", {hs1, vs1});
        end
        tests++;
        if (first != 37) begin
            fails++; $display("FAIL reset_first_vld got %0d want 37", first);
        end
    endtask

    task automatic test_timing;
        int hs_c, vs_c, n, sof_c, sof_bad, eol_c, eol_bad, ramp_bad, zero_bad;
        logic [7:0] n8;
        hs_c = 0; vs_c = 0; n = 0; sof_c = 0; sof_bad = 0; eol_c = 0; eol_bad = 0; ramp_bad = 0; zero_bad = 0;
        mode = 2'd0;
        do_reset();
        for (int k = 1; k <= 160; k++) begin
            tick();
            if (hs_q) hs_c++;
            if (vs_q) vs_c++;
            if (sof_q) sof_c++;
            if (eol_q) eol_c++;
            if (sof_q !== (vld_q && n == 0)) sof_bad++;
            if (eol_q !== (vld_q && (n % 8) == 7)) eol_bad++;
            if (vld_q) begin
                n8 = n[7:0];
                if (rgb !== {n8, n8, n8}) ramp_bad++;
                n++;
            end else if (rgb !== 24'h0) zero_bad++;
        end
        tests++; if (hs_c != 20)  begin fails++; $display("FAIL timing_hs_count got %0d want 20", hs_c); end
        tests++; if (vs_c != 16)  begin fails++; $display("FAIL timing_vs_count got %0d want 16", vs_c); end
        tests++; if (n != 48)     begin fails++; $display("FAIL timing_vld_count got %0d want 48", n); end
        tests++; if (sof_c != 1)  begin fails++; $display("FAIL timing_sof_count got %0d want 1", sof_c); end
        tests++; if (sof_bad != 0) begin fails++; $display("FAIL timing_sof_place got %0d bad want 0", sof_bad); end
        tests++; if (eol_c != 6)  begin fails++; $display("FAIL timing_eol_count got %0d want 6", eol_c); end
        tests++; if (eol_bad != 0) begin fails++; $display("FAIL timing_eol_place got %0d bad want 0", eol_bad); end
        tests++; if (ramp_bad != 0) begin fails++; $display("FAIL timing_ramp got %0d bad want 0", ramp_bad); end
        tests++; if (zero_bad != 0) begin fails++; $display("FAIL timing_rgb_idle got %0d bad want 0", zero_bad); end
    endtask

    task automatic test_mode_switch;
        logic [23:0] bar_tab [4];
        logic [23:0] p0, p3;
        logic [7:0]  n8;
        int n, ramp_bad, bar_bad;
        bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
        n = 0; ramp_bad = 0; bar_bad = 0; p0 = 24'hx; p3 = 24'hx;
        mode = 2'd0;
        do_reset();
        for (int k = 1; k <= 160; k++) begin
            if (k == 81) mode = 2'd1;
            tick();
            if (vld_q) begin
                n8 = n[7:0];
                if (rgb !== {n8, n8, n8}) ramp_bad++;
                n++;
            end
        end
        tests++; if (ramp_bad != 0 || n != 48) begin
            fails++; $display("FAIL switch_cur_frame got %0d bad %0d px want 0 bad 48 px", ramp_bad, n);
        end
        n = 0;
        for (int k = 161; k <= 320; k++) begin
            tick();
            if (vld_q) begin
                if (n == 0) p0 = rgb;
                if (n == 3) p3 = rgb;
                if (rgb !== bar_tab[(n % 8) / 2]) bar_bad++;
                n++;
            end
        end
        tests++; if (p0 !== 24'hFFFFFF) begin fails++; $display("FAIL bars_first_px got %h want ffffff", p0); end
        tests++; if (p3 !== 24'hFFFF00) begin fails++; $display("FAIL bars_px3 got %h want ffff00", p3); end
        tests++; if (bar_bad != 0) begin fails++; $display("FAIL bars_frame got %0d bad want 0", bar_bad); end
        mode = 2'd0;
    endtask

    task automatic test_checker;
        logic [23:0] p0, p1, p8, exp;
        int n, bad;
        n = 0; bad = 0; p0 = 24'hx; p1 = 24'hx; p8 = 24'hx;
        mode = 2'd2;
        do_reset();
        for (int k = 1; k <= 160; k++) begin
            tick();
            if (vld_q) begin
                exp = (((n % 8) ^ (n / 8)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
                if (n == 0) p0 = rgb;
                if (n == 1) p1 = rgb;
                if (n == 8) p8 = rgb;
                if (rgb !== exp) bad++;
                n++;
            end
        end
        tests++; if (p0 !== 24'h000000) begin fails++; $display("FAIL chk_px0 got %h want 000000", p0); end
        tests++; if (p1 !== 24'hFFFFFF) begin fails++; $display("FAIL chk_px1 got %h want ffffff", p1); end
        tests++; if (p8 !== 24'hFFFFFF) begin fails++; $display("FAIL chk_line1_px0 got %h want ffffff", p8); end
        tests++; if (bad != 0) begin fails++; $display("FAIL chk_frame got %0d bad want 0", bad); end
    endtask

    task automatic test_solid;
        int n, bad, idle_bad;
        n = 0; bad = 0; idle_bad = 0;
        mode = 2'd3; solid_rgb = 24'h123456;
        do_reset();
        for (int k = 1; k <= 160; k++) begin
            tick();
            if (vld_q) begin
                n++;
                if (rgb !== 24'h123456) bad++;
            end else if (rgb !== 24'h0) idle_bad++;
        end
        tests++; if (n != 48) begin fails++; $display("FAIL solid_count got %0d want 48", n); end
        tests++; if (bad != 0) begin fails++; $display("FAIL solid_colour got %0d bad want 0", bad); end
        tests++; if (idle_bad != 0) begin fails++; $display("FAIL solid_idle got %0d bad want 0", idle_bad); end
        mode = 2'd0;
    endtask

    task automatic test_en_gap;
        int n, eol_c, ramp_bad, gap_bad, hold_bad;
        logic hs_h, vs_h, hs_first;
        logic [7:0] n8;
        n = 0; eol_c = 0; ramp_bad = 0; gap_bad = 0; hold_bad = 0;
        hs_h = 1'b0; vs_h = 1'b0; hs_first = 1'b0;
        mode = 2'd0;
        do_reset();
        for (int s = 1; s <= 170; s++) begin
            en = !((s >= 18 && s <= 22) || (s >= 40 && s <= 44));
            tick();
            if (s == 17) begin hs_h = hs_q; vs_h = vs_q; hs_first = hs_q; end
            if (s == 39) begin hs_h = hs_q; vs_h = vs_q; end
            if (!en) begin
                if ({vld_q, sof_q, eol_q} !== 3'b0 || rgb !== 24'h0) gap_bad++;
                if (hs_q !== hs_h || vs_q !== vs_h) hold_bad++;
            end else begin
                if (eol_q) eol_c++;
                if (vld_q) begin
                    n8 = n[7:0];
                    if (rgb !== {n8, n8, n8}) ramp_bad++;
                    n++;
                end
            end
        end
        en = 1'b1;
        tests++; if (hs_first !== 1'b1) begin fails++; $display("FAIL gap_hs_before got %b want 1", hs_first); end
        tests++; if (gap_bad != 0)  begin fails++; $display("FAIL gap_outputs got %0d bad want 0", gap_bad); end
        tests++; if (hold_bad != 0) begin fails++; $display("FAIL gap_sync_hold got %0d bad want 0", hold_bad); end
        tests++; if (n != 48)       begin fails++; $display("FAIL gap_vld_count got %0d want 48", n); end
        tests++; if (eol_c != 6)    begin fails++; $display("FAIL gap_eol_count got %0d want 6", eol_c); end
        tests++; if (ramp_bad != 0) begin fails++; $display("FAIL gap_ramp got %0d bad want 0", ramp_bad); end
    endtask

    task automatic test_midframe_reset;
        int first;
        logic [23:0] rgb_first;
        logic sof_first;
        first = 0; rgb_first = 24'hx; sof_first = 1'b0;
        mode = 2'd0;
        do_reset();
        for (int k = 1; k <= 100; k++) tick();
        rst = 1'b1;
        tick();
        tests++;
        if ({hs_q, vs_q, vld_q, sof_q, eol_q} !== 5'b0 || rgb !== 24'h0) begin
            fails++; $display("FAIL midrst_outputs got %b/%h want 00000/000000", {hs_q, vs_q, vld_q, sof_q, eol_q}, rgb);
        end
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (vld_q && first == 0) begin first = k; rgb_first = rgb; sof_first = sof_q; end
        end
        tests++; if (first != 37) begin fails++; $display("FAIL midrst_first_vld got %0d want 37", first); end
        tests++; if (rgb_first !== 24'h0 || sof_first !== 1'b1) begin
            fails++; $display("FAIL midrst_restart got rgb %h sof %b want 000000 1", rgb_first, sof_first);
        end
    endtask

`ifdef TPG_FRAME_CNT_EN
    task automatic test_frame_cnt;
        logic [7:0]  f0, f1, f2;
        logic [23:0] px;
        logic        pv;
        f0 = 8'hx; f1 = 8'hx; f2 = 8'hx; px = 24'hx; pv = 1'b0;
        mode = 2'd0;
        do_reset();
        for (int k = 1; k <= 420; k++) begin
            tick();
            if (k == 100) f0 = frame_cnt;
            if (k == 260) f1 = frame_cnt;
            if (k == 357) begin px = rgb; pv = vld_q; end
            if (k == 420) f2 = frame_cnt;
        end
        tests++; if (f0 !== 8'd0) begin fails++; $display("FAIL fcnt_f0 got %0d want 0", f0); end
        tests++; if (f1 !== 8'd1) begin fails++; $display("FAIL fcnt_f1 got %0d want 1", f1); end
        tests++; if (f2 !== 8'd2) begin fails++; $display("FAIL fcnt_f2 got %0d want 2", f2); end
        tests++; if (px !== 24'h020202 || pv !== 1'b1) begin
            fails++; $display("FAIL fcnt_ramp got %h vld %b want 020202 1", px, pv);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_timing();
        test_mode_switch();
        test_checker();
        test_solid();
        test_en_gap();
        test_midframe_reset();
`ifdef TPG_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tpg_multi.md
Name: tpg_multi

Overview:
- Parametrised successor to the single-ramp test pattern generator.
- Runs a programmable raster timing: free-running x/y counters against runtime timing registers.
- Produces registered hsync, vsync, active-video and end-of-line/start-of-frame markers.
- Adds four selectable patterns (ramp, colour bars, checkerboard, solid); sits at the head of the video pipeline, feeding downstream stream blocks.

Parameters:
PW, 8, bits per colour component; rgb is 3*PW wide
H_BITS, 12, width of horizontal counter and horizontal timing inputs
V_BITS, 12, width of vertical counter and vertical timing inputs
BAR_SHIFT, 4, colour-bar width is 2**BAR_SHIFT pixels; bar index = hx[BAR_SHIFT+2:BAR_SHIFT]
CHK_SHIFT, 3, checker square size is 2**CHK_SHIFT pixels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  advance raster when 1; freeze when 0
mode  in  2  pattern select, sampled at frame start
solid_rgb  in  3*PW  colour for mode 3
tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END  in  H_BITS each  horizontal timing
tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END  in  V_BITS each  vertical timing
hs_q  out  1  hsync
vs_q  out  1  vsync
vld_q  out  1  active pixel
sof_q  out  1  first active pixel of frame
eol_q  out  1  last active pixel of line
rgb  out  3*PW  {R,G,B}, R in MSBs

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; clock is clk.
- Reset values: x=0, y=0, mode_r=0, cnt=0; hs_q, vs_q, vld_q, sof_q, eol_q and rgb all 0.
- Raster (en=1):
  - x increments each cycle.
  - At x==tH_END: x<=0 and y increments.
  - At x==tH_END and y==tV_END: y<=0, i.e. a frame wrap.
- Timing inputs are assumed static while en=1; changes take effect the next cycle with no protection.
- Decode from current x,y, comparisons unsigned, intervals half-open:
  - hs = tHS_START<=x<tHS_END; vs = tVS_START<=y<tVS_END.
  - act = tHACT_START<=x<tHACT_END && tVACT_START<=y<tVACT_END.
  - START>=END yields a never-asserted signal.
- Outputs are registered: each output reflects the (x,y) of the previous cycle, giving latency 1.
- en=0: x, y and cnt hold; hs_q and vs_q hold; vld_q, sof_q, eol_q forced 0; rgb forced 0.
  - When en returns, the raster resumes from the held position.
- mode_r is loaded from mode when x==0 && y==0 && en; otherwise it holds, so a pattern never changes mid-frame.
- Relative coordinates: hx = x - tHACT_START, vy = y - tVACT_START, both modulo width.
- Patterns (only meaningful when act; rgb=0 when !act):
  - mode 0, ramp: component = cnt; cnt increments after each active pixel, wraps at 2**PW, and clears to 0 at x==0,y==0.
  - mode 1, bars: b = hx[BAR_SHIFT+2:BAR_SHIFT]; R = ~b[1], G = ~b[2], B = ~b[0]. Each bit is expanded to all-ones or zero, giving white, yellow, cyan, green, magenta, red, blue, black. Bars repeat every 8.
  - mode 2, checker: white if hx[CHK_SHIFT]^vy[CHK_SHIFT] else black.
  - mode 3: rgb = solid_rgb.
- sof_q is set for the act pixel with x==tHACT_START && y==tVACT_START.
- eol_q is set for the act pixel with x==tHACT_END-1.
- Counters wrap naturally if tH_END/tV_END equal all-ones. tH_END=0 gives a one-pixel line; y then advances every cycle.
- Reset asserted mid-frame: all state returns to reset values on the next edge; the raster restarts at (0,0).

Optional Feature:
TPG_FRAME_CNT_EN
- Defined:
  - Adds port frame_cnt out, 8 bits, reset 0. It increments on every frame wrap while en=1 and wraps at 255.
  - Modes 0 and 2 become moving: mode 0 component = cnt + frame_cnt (PW-bit wrap); mode 2 uses hx + frame_cnt in place of hx.
- Undefined: no frame_cnt port; patterns are static as described above.

Test Plan:
- Timing setup: tH_END=15, tHS 0..2, tHACT 4..12, tV_END=9, tVS 0..1, tVACT 2..8, mode 0, en=1 after reset. Required response:
  - hs_q high for 2 of every 16 cycles.
  - 8 vld_q per line on 6 lines, i.e. 48 per frame.
  - rgb ramps 0..47 per frame; sof_q once per frame at the first vld; eol_q on the 8th vld of each line.
- Reset behaviour: all outputs 0 during rst.
  - First vld_q appears 2*16+4+1 = 37 cycles after rst deasserts.
  - Assert rst mid-frame for one cycle: raster restarts from (0,0).
- Mode switch: set mode=1 (BAR_SHIFT=1) mid-frame.
  - Current frame stays ramp.
  - Next frame gives 2-pixel bars white, yellow, cyan, green; the first active pixel has rgb={FF,FF,FF}, and pixel 3 has rgb={FF,FF,00}.
- Checker and solid: mode=2 with CHK_SHIFT=0 gives alternating white/black, with phase inverting each line. mode=3 with solid_rgb=0x123456 gives rgb=0x123456 only while vld_q.
- en behaviour: drop en for 5 cycles mid-line.
  - vld_q and rgb are 0 during the gap; hs_q is held.
  - After the gap the line resumes with no pixels lost (8 vld per line total).
- TPG_FRAME_CNT_EN: frame_cnt reads 0, 1, 2 across 3 frames; mode 0 first active pixel of frame 2 has rgb component 2.
